// File: rtl/stage_decode_elastic_pkg.sv
// Shared pipeline types for the decode stage: IF/ID and ID/EX payloads, decode bundle, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage_decode_elastic_pkg;

   localparam int PKG_XLEN = 32;

   // RV32 major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Branch func3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Immediate format select
   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;

   // Output buffer occupancy states
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [PKG_XLEN-1:0] pc_plus4;
      logic                instr_valid;
   } if_id_reg_t;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [PKG_XLEN-1:0] pc_plus4;
      logic [31:0]         instr;
      logic [PKG_XLEN-1:0] rs1_data;
      logic [PKG_XLEN-1:0] rs2_data;
      logic [PKG_XLEN-1:0] imm;
      logic [4:0]          rd;
      logic                rd_we;
      logic                is_load;
      logic                is_store;
      logic                is_branch;
      logic                is_jump;
      logic                br_taken;
      logic                instr_valid;
   } id_ex_reg_t;

   typedef struct packed {
      logic       legal;
      logic       uses_rs1;
      logic       uses_rs2;
      logic       rd_we;
      logic       is_branch;
      logic       is_jal;
      logic       is_jalr;
      logic       is_load;
      logic       is_store;
      logic [2:0] imm_sel;
   } dec_t;

endpackage

// File: rtl/stage_decode_elastic_instr_decoder.sv
// Control decoder: opcode/func3 -> legality, operand usage, class flags, immediate format.
// Latency: purely combinational.
// Backpressure: none; ports i_opcode/i_func3 in, o_dec bundle out.
module stage_decode_elastic_instr_decoder
   import stage_decode_elastic_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_func3,
   output dec_t       o_dec
);

   always_comb begin
      o_dec = '0;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC: begin
            o_dec.legal   = 1'b1;
            o_dec.rd_we   = 1'b1;
            o_dec.imm_sel = IMM_U;
         end
         OPC_JAL: begin
            o_dec.legal   = 1'b1;
            o_dec.rd_we   = 1'b1;
            o_dec.is_jal  = 1'b1;
            o_dec.imm_sel = IMM_J;
         end
         OPC_JALR: begin
            o_dec.legal    = 1'b1;
            o_dec.rd_we    = 1'b1;
            o_dec.is_jalr  = 1'b1;
            o_dec.uses_rs1 = 1'b1;
            o_dec.imm_sel  = IMM_I;
         end
         OPC_BRANCH: begin
            // func3 010/011 are unassigned branch encodings
            o_dec.legal     = (i_func3 != 3'b010) && (i_func3 != 3'b011);
            o_dec.is_branch = 1'b1;
            o_dec.uses_rs1  = 1'b1;
            o_dec.uses_rs2  = 1'b1;
            o_dec.imm_sel   = IMM_B;
         end
         OPC_LOAD: begin
            o_dec.legal    = 1'b1;
            o_dec.rd_we    = 1'b1;
            o_dec.is_load  = 1'b1;
            o_dec.uses_rs1 = 1'b1;
            o_dec.imm_sel  = IMM_I;
         end
         OPC_STORE: begin
            o_dec.legal    = 1'b1;
            o_dec.is_store = 1'b1;
            o_dec.uses_rs1 = 1'b1;
            o_dec.uses_rs2 = 1'b1;
            o_dec.imm_sel  = IMM_S;
         end
         OPC_OPIMM: begin
            o_dec.legal    = 1'b1;
            o_dec.rd_we    = 1'b1;
            o_dec.uses_rs1 = 1'b1;
            o_dec.imm_sel  = IMM_I;
         end
         OPC_OP: begin
            o_dec.legal    = 1'b1;
            o_dec.rd_we    = 1'b1;
            o_dec.uses_rs1 = 1'b1;
            o_dec.uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stage_decode_elastic.sv
// Decode stage: operand forwarding, branch/jump resolution with PC redirect, 2-entry elastic output buffer.
// Latency: 1 cycle IF->EX payload when the buffer is empty; redirect is combinational in the accept cycle.
// Backpressure: in_ready_o drops on full buffer, pending-forward hazard, squash or reset; never on out_ready_i.
// Ports: IF handshake + if_id_reg_i/instr_i, RF read addr/data, forwarding sources, squash_i,
//        EX handshake + id_ex_reg_o, redirect_valid_o/addr_o, saturating stall/redirect counters.
module stage_decode_elastic
   import stage_decode_elastic_pkg::*;
#(
   parameter int XLEN    = PKG_XLEN,
   parameter int NUM_FWD = 2,
   parameter int CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst_ni,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [31:0]                    instr_i,
   input  if_id_reg_t                     if_id_reg_i,
   output logic [4:0]                     rs1_addr_o,
   output logic [4:0]                     rs2_addr_o,
   input  logic [XLEN-1:0]                data_rs1_i,
   input  logic [XLEN-1:0]                data_rs2_i,
   input  logic [NUM_FWD-1:0]             fwd_valid_i,
   input  logic [NUM_FWD-1:0]             fwd_pending_i,
   input  logic [NUM_FWD-1:0][4:0]        fwd_rd_i,
   input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data_i,
   input  logic                           squash_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output id_ex_reg_t                     id_ex_reg_o,
   output logic                           redirect_valid_o,
   output logic [XLEN-1:0]                redirect_addr_o,
   output logic [CNT_W-1:0]               stall_cnt_o,
   output logic [CNT_W-1:0]               redirect_cnt_o
);

   dec_t             w_dec;
   logic [XLEN-1:0]  w_imm, w_rs1, w_rs2;
   logic             w_rs1_pend, w_rs2_pend, w_hazard, w_cond, w_taken;
   logic             w_in_fire, w_out_fire, w_pay_valid, w_stall;
   id_ex_reg_t       w_new;
   logic [1:0]       r_state;
   id_ex_reg_t       r_ent0, r_ent1;
   logic [CNT_W-1:0] r_stall_cnt, r_redir_cnt;

   stage_decode_elastic_instr_decoder u_dec (
      .i_opcode (instr_i[6:0]),
      .i_func3  (instr_i[14:12]),
      .o_dec    (w_dec)
   );

   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   always_comb begin
      w_imm = '0;
      case (w_dec.imm_sel)
         IMM_I:   w_imm = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   w_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   w_imm = {instr_i[31:12], 12'b0};
         IMM_J:   w_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end

   // Walk sources oldest-to-youngest so the lowest index wins the last assignment.
   always_comb begin
      w_rs1      = data_rs1_i;
      w_rs2      = data_rs2_i;
      w_rs1_pend = 1'b0;
      w_rs2_pend = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid_i[i] && (fwd_rd_i[i] == rs1_addr_o)) begin
            w_rs1      = fwd_data_i[i];
            w_rs1_pend = fwd_pending_i[i];
         end
         if (fwd_valid_i[i] && (fwd_rd_i[i] == rs2_addr_o)) begin
            w_rs2      = fwd_data_i[i];
            w_rs2_pend = fwd_pending_i[i];
         end
      end
      if (rs1_addr_o == 5'd0) begin
         w_rs1      = '0;
         w_rs1_pend = 1'b0;
      end
      if (rs2_addr_o == 5'd0) begin
         w_rs2      = '0;
         w_rs2_pend = 1'b0;
      end
   end

   assign w_hazard = (w_dec.uses_rs1 & w_rs1_pend) | (w_dec.uses_rs2 & w_rs2_pend);

   always_comb begin
      w_cond = 1'b0;
      case (instr_i[14:12])
         F3_BEQ:  w_cond = (w_rs1 == w_rs2);
         F3_BNE:  w_cond = (w_rs1 != w_rs2);
         F3_BLT:  w_cond = ($signed(w_rs1) <  $signed(w_rs2));
         F3_BGE:  w_cond = ($signed(w_rs1) >= $signed(w_rs2));
         F3_BLTU: w_cond = (w_rs1 <  w_rs2);
         F3_BGEU: w_cond = (w_rs1 >= w_rs2);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken     = w_dec.is_branch & w_dec.legal & w_cond;
   assign w_pay_valid = if_id_reg_i.instr_valid & w_dec.legal;

   assign in_ready_o  = rst_ni & (r_state != ST_TWO) & ~w_hazard & ~squash_i;
   assign out_valid_o = (r_state == ST_ONE) || (r_state == ST_TWO);
   assign w_in_fire   = in_valid_i & in_ready_o;
   assign w_out_fire  = out_valid_o & out_ready_i;
   assign w_stall     = in_valid_i & ~in_ready_o;

   // Squash already blocks w_in_fire through in_ready_o, so no separate gate is needed here.
   assign redirect_valid_o = w_in_fire & w_pay_valid & (w_dec.is_jal | w_dec.is_jalr | w_taken);
   assign redirect_addr_o  = w_dec.is_jalr ? ((w_rs1 + w_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                           : (if_id_reg_i.pc + w_imm);

   always_comb begin
      w_new             = '0;
      w_new.pc          = if_id_reg_i.pc;
      w_new.pc_plus4    = if_id_reg_i.pc_plus4;
      w_new.instr       = instr_i;
      w_new.rs1_data    = w_rs1;
      w_new.rs2_data    = w_rs2;
      w_new.imm         = w_imm;
      w_new.rd          = instr_i[11:7];
      w_new.rd_we       = w_dec.rd_we;
      w_new.is_load     = w_dec.is_load;
      w_new.is_store    = w_dec.is_store;
      w_new.is_branch   = w_dec.is_branch;
      w_new.is_jump     = w_dec.is_jal | w_dec.is_jalr;
      w_new.br_taken    = w_taken;
      w_new.instr_valid = w_pay_valid;
   end

   // r_ent0 is always the oldest entry and drives the output directly.
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         r_state <= ST_EMPTY;
         r_ent0  <= '0;
         r_ent1  <= '0;
      end else if (squash_i) begin
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_in_fire) begin
               r_ent0  <= w_new;
               r_state <= ST_ONE;
            end
            ST_ONE: begin
               if (w_in_fire && !w_out_fire) begin
                  r_ent1  <= w_new;
                  r_state <= ST_TWO;
               end else if (w_out_fire && !w_in_fire) begin
                  r_state <= ST_EMPTY;
               end else if (w_in_fire) begin
                  r_ent0  <= w_new;
               end
            end
            ST_TWO: if (w_out_fire) begin
               r_ent0  <= r_ent1;
               r_state <= ST_ONE;
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (redirect_valid_o && (r_redir_cnt != '1))
            r_redir_cnt <= r_redir_cnt + CNT_W'(1);
      end
   end

   assign id_ex_reg_o    = r_ent0;
   assign stall_cnt_o    = r_stall_cnt;
   assign redirect_cnt_o = r_redir_cnt;

endmodule

// File: tb/tb_stage_decode_elastic.sv
module tb_stage_decode_elastic;
   import stage_decode_elastic_pkg::*;

   logic             clk;
   logic             rst_ni;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      instr_i;
   if_id_reg_t       if_id_reg_i;
   logic [4:0]       rs1_addr_o, rs2_addr_o;
   logic [31:0]      data_rs1_i, data_rs2_i;
   logic [1:0]       fwd_valid_i, fwd_pending_i;
   logic [1:0][4:0]  fwd_rd_i;
   logic [1:0][31:0] fwd_data_i;
   logic             squash_i;
   logic             out_valid_o, out_ready_i;
   id_ex_reg_t       id_ex_reg_o;
   logic             redirect_valid_o;
   logic [31:0]      redirect_addr_o;
   logic [15:0]      stall_cnt_o, redirect_cnt_o;

   int n_checks = 0;
   int n_err    = 0;

   stage_decode_elastic dut (
      .clk              (clk),
      .rst_ni           (rst_ni),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .instr_i          (instr_i),
      .if_id_reg_i      (if_id_reg_i),
      .rs1_addr_o       (rs1_addr_o),
      .rs2_addr_o       (rs2_addr_o),
      .data_rs1_i       (data_rs1_i),
      .data_rs2_i       (data_rs2_i),
      .fwd_valid_i      (fwd_valid_i),
      .fwd_pending_i    (fwd_pending_i),
      .fwd_rd_i         (fwd_rd_i),
      .fwd_data_i       (fwd_data_i),
      .squash_i         (squash_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .id_ex_reg_o      (id_ex_reg_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_addr_o  (redirect_addr_o),
      .stall_cnt_o      (stall_cnt_o),
      .redirect_cnt_o   (redirect_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_payload_zero(input string tag);
      n_checks++;
      assert (id_ex_reg_o === '0) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=0", tag, id_ex_reg_o);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      instr_i                 = ins;
      if_id_reg_i.pc          = pc;
      if_id_reg_i.pc_plus4    = pc + 32'd4;
      if_id_reg_i.instr_valid = 1'b1;
   endtask

   // Encodings (hand assembled):
   //   beq  x5,x5,+16 = 00528863   beq-form f3=010 = 0052A863
   //   blt  x5,x6,+16 = 0062C863   bltu x5,x6,+16 = 0062E863
   //   jalr x1,2(x7)  = 002380E7   jal  x1,+8      = 008000EF
   //   addi x4,x3,1   = 00118213   addi x4,x0,k    = 00k00213
   initial begin
      rst_ni = 1'b0; in_valid_i = 1'b0; instr_i = '0; if_id_reg_i = '0;
      data_rs1_i = '0; data_rs2_i = '0; fwd_valid_i = '0; fwd_pending_i = '0;
      fwd_rd_i = '0; fwd_data_i = '0; squash_i = 1'b0; out_ready_i = 1'b1;
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      chk("rst_redir_cnt", 32'(redirect_cnt_o), 32'd0);
      chk_payload_zero("rst_payload");
      rst_ni = 1'b1;

      // BEQ taken from EMPTY
      out_ready_i = 1'b0;
      drive(32'h00528863, 32'h100);
      data_rs1_i = 32'h55; data_rs2_i = 32'h55; in_valid_i = 1'b1;
      #1;
      chk("beq_rs1_addr", 32'(rs1_addr_o), 32'd5);
      chk("beq_in_ready", 32'(in_ready_o), 32'd1);
      chk("beq_redir_vld", 32'(redirect_valid_o), 32'd1);
      chk("beq_redir_addr", redirect_addr_o, 32'h110);
      tick(); in_valid_i = 1'b0; #1;
      chk("beq_out_valid", 32'(out_valid_o), 32'd1);
      chk("beq_taken", 32'(id_ex_reg_o.br_taken), 32'd1);
      chk("beq_pc", id_ex_reg_o.pc, 32'h100);
      chk("beq_redir_idle", 32'(redirect_valid_o), 32'd0);
      chk("beq_redir_cnt", 32'(redirect_cnt_o), 32'd1);
      out_ready_i = 1'b1;
      tick();
      chk("beq_drained", 32'(out_valid_o), 32'd0);

      // JALR with rs1 from source 0 (source 1 also matches and must lose)
      drive(32'h002380E7, 32'h300);
      data_rs1_i = 32'h0; fwd_valid_i = 2'b11;
      fwd_rd_i[0] = 5'd7; fwd_rd_i[1] = 5'd7;
      fwd_data_i[0] = 32'h2001; fwd_data_i[1] = 32'h4000;
      in_valid_i = 1'b1;
      #1;
      chk("jalr_redir_vld", 32'(redirect_valid_o), 32'd1);
      chk("jalr_redir_addr", redirect_addr_o, 32'h2002);
      tick(); in_valid_i = 1'b0; fwd_valid_i = '0; #1;
      chk("jalr_rs1_data", id_ex_reg_o.rs1_data, 32'h2001);
      chk("jalr_is_jump", 32'(id_ex_reg_o.is_jump), 32'd1);
      chk("jalr_redir_cnt", 32'(redirect_cnt_o), 32'd2);
      tick();

      // x0 source: never forwarded, pending on x0 is no hazard
      drive(32'h00500213, 32'h320);
      data_rs1_i = 32'h123; fwd_valid_i = 2'b01; fwd_rd_i[0] = 5'd0;
      fwd_data_i[0] = 32'h999; fwd_pending_i = 2'b01; in_valid_i = 1'b1;
      #1;
      chk("x0_in_ready", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; fwd_valid_i = '0; fwd_pending_i = '0; #1;
      chk("x0_rs1_data", id_ex_reg_o.rs1_data, 32'h0);
      chk("x0_imm", id_ex_reg_o.imm, 32'h5);
      tick();

      // Illegal branch func3 010: not taken, payload marked invalid
      drive(32'h0052A863, 32'h100);
      data_rs1_i = 32'h55; data_rs2_i = 32'h55; in_valid_i = 1'b1;
      #1;
      chk("ill_redir_vld", 32'(redirect_valid_o), 32'd0);
      tick(); in_valid_i = 1'b0; #1;
      chk("ill_out_valid", 32'(out_valid_o), 32'd1);
      chk("ill_instr_valid", 32'(id_ex_reg_o.instr_valid), 32'd0);
      tick();

      // Signed vs unsigned less-than with rs1=-1, rs2=1
      drive(32'h0062C863, 32'h400);
      data_rs1_i = 32'hFFFF_FFFF; data_rs2_i = 32'h1; in_valid_i = 1'b1;
      #1;
      chk("blt_rs2_addr", 32'(rs2_addr_o), 32'd6);
      chk("blt_redir_vld", 32'(redirect_valid_o), 32'd1);
      chk("blt_redir_addr", redirect_addr_o, 32'h410);
      tick();
      drive(32'h0062E863, 32'h404);
      #1;
      chk("bltu_redir_vld", 32'(redirect_valid_o), 32'd0);
      chk("bltu_in_ready", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; #1;
      chk("bltu_taken", 32'(id_ex_reg_o.br_taken), 32'd0);
      chk("blt_redir_cnt", 32'(redirect_cnt_o), 32'd3);
      tick();

      // Pending forward from source 1 on x3 for three cycles
      chk("haz_stall_base", 32'(stall_cnt_o), 32'd0);
      drive(32'h00118213, 32'h500);
      data_rs1_i = 32'h0; fwd_valid_i = 2'b10; fwd_rd_i[1] = 5'd3;
      fwd_data_i[1] = 32'h77; fwd_pending_i = 2'b10; in_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("haz_in_ready", 32'(in_ready_o), 32'd0);
         @(posedge clk);
         #1;
      end
      chk("haz_stall_cnt", 32'(stall_cnt_o), 32'd3);
      fwd_pending_i = 2'b00;
      #1;
      chk("haz_release", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; fwd_valid_i = '0; #1;
      chk("haz_rs1_data", id_ex_reg_o.rs1_data, 32'h77);
      chk("haz_stall_hold", 32'(stall_cnt_o), 32'd3);
      tick();

      // Three back-to-back inputs against a blocked output; FIFO order 1,2,3
      out_ready_i = 1'b0;
      drive(32'h00100213, 32'h600); in_valid_i = 1'b1;
      tick();
      drive(32'h00200213, 32'h604);
      #1;
      chk("fifo_one_valid", 32'(out_valid_o), 32'd1);
      chk("fifo_one_ready", 32'(in_ready_o), 32'd1);
      tick();
      drive(32'h00300213, 32'h608);
      #1;
      chk("fifo_two_ready", 32'(in_ready_o), 32'd0);
      tick();
      chk("fifo_hold_1", id_ex_reg_o.imm, 32'd1);
      out_ready_i = 1'b1;
      #1;
      chk("fifo_ready_indep", 32'(in_ready_o), 32'd0);
      tick();
      chk("fifo_out_2", id_ex_reg_o.imm, 32'd2);
      chk("fifo_accept3", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; #1;
      chk("fifo_out_3", id_ex_reg_o.imm, 32'd3);
      tick();
      chk("fifo_empty", 32'(out_valid_o), 32'd0);
      chk("fifo_stall_cnt", 32'(stall_cnt_o), 32'd5);

      // Squash in TWO with simultaneous output fire and a JAL offered
      out_ready_i = 1'b0;
      drive(32'h00100213, 32'h700); in_valid_i = 1'b1;
      tick();
      drive(32'h00200213, 32'h704);
      tick();
      drive(32'h008000EF, 32'h200);
      squash_i = 1'b1; out_ready_i = 1'b1;
      #1;
      chk("sq_in_ready", 32'(in_ready_o), 32'd0);
      chk("sq_redir_vld", 32'(redirect_valid_o), 32'd0);
      tick(); squash_i = 1'b0; in_valid_i = 1'b0; #1;
      chk("sq_out_valid", 32'(out_valid_o), 32'd0);
      chk("sq_redir_cnt", 32'(redirect_cnt_o), 32'd3);
      chk("sq_stall_cnt", 32'(stall_cnt_o), 32'd6);

      // JAL accepted normally
      drive(32'h008000EF, 32'h200); in_valid_i = 1'b1;
      #1;
      chk("jal_redir_vld", 32'(redirect_valid_o), 32'd1);
      chk("jal_redir_addr", redirect_addr_o, 32'h208);
      tick(); in_valid_i = 1'b0; #1;
      chk("jal_rd", 32'(id_ex_reg_o.rd), 32'd1);
      chk("jal_redir_cnt", 32'(redirect_cnt_o), 32'd4);
      tick();

      // Reset for one cycle while in TWO
      out_ready_i = 1'b0;
      drive(32'h00100213, 32'h800); in_valid_i = 1'b1;
      tick();
      drive(32'h00200213, 32'h804);
      tick();
      in_valid_i = 1'b0; rst_ni = 1'b0;
      tick();
      drive(32'h00100213, 32'h900); in_valid_i = 1'b1;
      #1;
      chk("rst2_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst2_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst2_stall_cnt", 32'(stall_cnt_o), 32'd0);
      chk("rst2_redir_cnt", 32'(redirect_cnt_o), 32'd0);
      chk_payload_zero("rst2_payload");
      rst_ni = 1'b1;
      #1;
      chk("rst2_ready_after", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; #1;
      chk("rst2_accept_valid", 32'(out_valid_o), 32'd1);
      chk("rst2_accept_pc", id_ex_reg_o.pc, 32'h900);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
